uart_xfer_ctrl: RTL and testbench
=================================

Name: uart_xfer_ctrl

Overview:
Hardware sequencer that drives the UART register block through its ICB slave port as the single bus master. On start it writes the CSR and CTRL registers. It then runs a per-byte loop: write DATA, poll the CSR tx_ok flag (bit 4) until it is set, read DATA, poll until it clears. Bytes go in and out through valid/ready streams, so a DMA or CPU-side FIFO can move data without software polling.

Parameters:
CSR_ADDR, 32'h1000_0000, ICB address of the UART CSR register
CTRL_ADDR, 32'h1000_0004, ICB address of the UART CTRL register
DATA_ADDR, 32'h1000_0008, ICB address of the UART DATA register
POLL_MAX, 65535, maximum CSR poll reads per wait phase before timeout (1..65535)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin the config sequence when idle
stop  in  1  level; return to IDLE at the next byte boundary
cfg_csr  in  32  value written to CSR (baud divisor and enables)
cfg_ctrl  in  32  value written to CTRL (parity and format)
busy  out  1  high whenever the FSM is not in IDLE
err_timeout  out  1  sticky; a poll phase exceeded POLL_MAX
tx_valid  in  1  byte available
tx_ready  out  1  controller accepts a byte
tx_data  in  8  byte to send
rx_valid  out  1  returned byte valid
rx_ready  in  1  consumer accepts the byte
rx_data  out  8  byte read back from DATA
icb_cmd_valid  out  1  ICB command valid
icb_cmd_ready  in  1  ICB command ready
icb_cmd_addr  out  32  ICB address
icb_cmd_read  out  1  1 = read, 0 = write
icb_cmd_wdata  out  32  ICB write data
icb_rsp_valid  in  1  ICB response valid
icb_rsp_ready  out  1  ICB response ready
icb_rsp_rdata  in  32  ICB read data
mismatch_cnt  out  8  loopback mismatch count (see Optional Feature)

Behaviour:
- Reset (asynchronous) values:
  - all outputs 0 except tx_ready, which follows the state (0 in IDLE).
  - FSM in IDLE; poll counter 0; latched byte 0.
- Bus rule: at most one ICB transaction outstanding.
  - Each bus state has a CMD phase: icb_cmd_valid=1, with addr/read/wdata held stable until icb_cmd_ready.
  - The same cycle the command is accepted, the state moves to its RSP phase: icb_rsp_ready=1, waiting for icb_rsp_valid.
  - icb_rsp_ready=0 outside RSP phases.
  - Write data is zero-extended: {24'b0, byte}.
- States and transitions:
  - IDLE: on start, latch cfg_csr and cfg_ctrl, clear err_timeout, go to CFG_CSR. start while busy is ignored.
  - CFG_CSR: write cfg_csr to CSR_ADDR; on response go to CFG_CTRL.
  - CFG_CTRL: write cfg_ctrl to CTRL_ADDR; on response go to WAIT_BYTE.
  - WAIT_BYTE: if stop, go to IDLE. Otherwise tx_ready=1; on tx_valid, latch tx_data and go to WR_DATA. stop has priority over tx_valid in the same cycle.
  - WR_DATA: write the byte to DATA_ADDR; on response go to POLL_SET with the poll counter cleared.
  - POLL_SET: read CSR_ADDR back-to-back (next command is issued the cycle after the response), incrementing the counter per response.
    - rdata[4]=1: go to RD_DATA.
    - counter reaches POLL_MAX with bit 4 still 0: set err_timeout, go to WAIT_BYTE (byte dropped, no rx_valid).
  - RD_DATA: read DATA_ADDR, capture rdata[7:0] into rx_data, go to OUT_BYTE.
  - OUT_BYTE: rx_valid=1 and rx_data held until rx_ready. On handshake, go to POLL_CLR with the counter cleared. No ICB commands are issued while stalled here.
  - POLL_CLR: same polling as POLL_SET, waiting for rdata[4]=0.
    - flag clear: go to WAIT_BYTE.
    - counter reaches POLL_MAX: set err_timeout, go to WAIT_BYTE.
- Minimum latency, byte accept to rx_valid, with zero-wait ICB and a flag set on the first poll: 7 cycles (WR cmd, WR rsp, poll cmd, poll rsp, RD cmd, RD rsp, valid).
- stop is sampled only in WAIT_BYTE; an in-flight byte always completes its loop.
- Reset mid-transaction: immediate return to IDLE with icb_cmd_valid=0. No recovery of the outstanding response is attempted; the UART is reset with the same rst_n.
- Poll counter is 16 bits and never wraps: it is compared before incrementing.

Optional Feature:
UART_XFER_LOOPCHK_EN
- Defined: in OUT_BYTE on handshake, rx_data is compared with the latched tx byte. On mismatch, mismatch_cnt increments, saturating at 8'hFF. It is cleared on start.
- Undefined: mismatch_cnt is tied to 8'h00 and no comparator is built.

Test Plan:
1. Config: start with cfg_csr=32'h004D_0001, cfg_ctrl=32'h0001_0111 -> ICB write 0x004D0001 to CSR_ADDR, then 0x00010111 to CTRL_ADDR; busy=1; then tx_ready=1.
2. Byte 8'hA5, slave model sets CSR bit 4 on the 3rd poll and clears it on the 2nd clear-poll -> sequence WR DATA 0x000000A5, 3 CSR reads, DATA read, rx_valid with rx_data=8'hA5, 2 CSR reads, tx_ready=1; with the macro defined, mismatch_cnt=0.
3. icb_cmd_ready low for 5 cycles on WR_DATA -> addr/wdata/read stable throughout, exactly one write accepted.
4. POLL_MAX=8, bit 4 never set -> exactly 8 CSR reads, err_timeout=1, no rx_valid, tx_ready=1 next; the next start clears err_timeout.
5. rx_ready low for 10 cycles in OUT_BYTE -> rx_valid=1 and rx_data stable, icb_cmd_valid=0 throughout; stop asserted during the byte -> IDLE only after POLL_CLR completes.
6. rst_n asserted mid POLL_SET -> busy=0, icb_cmd_valid=0, tx_ready=0 with no clock edge; start after reset restarts at CFG_CSR.

Source files
------------

// File: rtl/uart_xfer_ctrl.sv
// ICB bus master that configures the UART, then moves bytes through a write/poll/read/poll loop.
// Define UART_XFER_LOOPCHK_EN to build the loopback compare that drives mismatch_cnt.
module uart_xfer_ctrl #(
  parameter logic [31:0] CSR_ADDR  = 32'h1000_0000,
  parameter logic [31:0] CTRL_ADDR = 32'h1000_0004,
  parameter logic [31:0] DATA_ADDR = 32'h1000_0008,
  parameter int unsigned POLL_MAX  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_csr,
  input  logic [31:0] cfg_ctrl,
  output logic        busy,
  output logic        err_timeout,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic [31:0] icb_cmd_addr,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_wdata,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata,
  output logic [7:0]  mismatch_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_CSR, S_CFG_CTRL, S_WAIT_BYTE, S_WR_DATA,
    S_POLL_SET, S_RD_DATA, S_OUT_BYTE, S_POLL_CLR
  } state_e;

  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);

  state_e      state_q, state_d;
  logic        rsp_q, rsp_d;  // low: CMD phase, high: RSP phase of the current bus state
  logic [31:0] csr_q, csr_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        err_q, err_d;
  logic        bus_state, rsp_done, rx_hs;
  logic        unused_rdata;

  assign unused_rdata = ^icb_rsp_rdata[31:8];

  assign bus_state = (state_q == S_CFG_CSR)  || (state_q == S_CFG_CTRL) ||
                     (state_q == S_WR_DATA)  || (state_q == S_POLL_SET) ||
                     (state_q == S_RD_DATA)  || (state_q == S_POLL_CLR);

  assign busy          = (state_q != S_IDLE);
  assign tx_ready      = (state_q == S_WAIT_BYTE) && !stop;
  assign rx_valid      = (state_q == S_OUT_BYTE);
  assign rx_data       = rx_data_q;
  assign err_timeout   = err_q;
  assign icb_cmd_valid = bus_state && !rsp_q;
  assign icb_rsp_ready = bus_state && rsp_q;
  assign rsp_done      = icb_rsp_ready && icb_rsp_valid;
  assign rx_hs         = rx_valid && rx_ready;

  always_comb begin
    icb_cmd_addr  = 32'h0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = 32'h0;
    case (state_q)
      S_CFG_CSR:  begin icb_cmd_addr = CSR_ADDR;  icb_cmd_wdata = csr_q; end
      S_CFG_CTRL: begin icb_cmd_addr = CTRL_ADDR; icb_cmd_wdata = ctrl_q; end
      S_WR_DATA:  begin icb_cmd_addr = DATA_ADDR; icb_cmd_wdata = {24'h0, byte_q}; end
      S_POLL_SET,
      S_POLL_CLR: begin icb_cmd_addr = CSR_ADDR;  icb_cmd_read = 1'b1; end
      S_RD_DATA:  begin icb_cmd_addr = DATA_ADDR; icb_cmd_read = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rsp_d      = rsp_q;
    csr_d      = csr_q;
    ctrl_d     = ctrl_q;
    byte_d     = byte_q;
    rx_data_d  = rx_data_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = err_q;
    if (icb_cmd_valid && icb_cmd_ready) rsp_d = 1'b1;
    if (rsp_done) rsp_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        csr_d   = cfg_csr;
        ctrl_d  = cfg_ctrl;
        err_d   = 1'b0;
        state_d = S_CFG_CSR;
      end
      S_CFG_CSR:  if (rsp_done) state_d = S_CFG_CTRL;
      S_CFG_CTRL: if (rsp_done) state_d = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tx_valid) begin
          byte_d  = tx_data;
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: if (rsp_done) begin
        poll_cnt_d = 16'h0;
        state_d    = S_POLL_SET;
      end
      // Counter is compared before incrementing so it never wraps
      S_POLL_SET: if (rsp_done) begin
        if (icb_rsp_rdata[4]) begin
          state_d = S_RD_DATA;
        end else if (poll_cnt_q == POLL_LAST) begin
          err_d   = 1'b1;
          state_d = S_WAIT_BYTE;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end
      S_RD_DATA: if (rsp_done) begin
        rx_data_d = icb_rsp_rdata[7:0];
        state_d   = S_OUT_BYTE;
      end
      S_OUT_BYTE: if (rx_hs) begin
        poll_cnt_d = 16'h0;
        state_d    = S_POLL_CLR;
      end
      S_POLL_CLR: if (rsp_done) begin
        if (!icb_rsp_rdata[4]) begin
          state_d = S_WAIT_BYTE;
        end else if (poll_cnt_q == POLL_LAST) begin
          err_d   = 1'b1;
          state_d = S_WAIT_BYTE;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rsp_q      <= 1'b0;
      csr_q      <= 32'h0;
      ctrl_q     <= 32'h0;
      byte_q     <= 8'h0;
      rx_data_q  <= 8'h0;
      poll_cnt_q <= 16'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
      csr_q      <= csr_d;
      ctrl_q     <= ctrl_d;
      byte_q     <= byte_d;
      rx_data_q  <= rx_data_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef UART_XFER_LOOPCHK_EN
  logic [7:0] mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if ((state_q == S_IDLE) && start) begin
      mis_d = 8'h0;
    end else if (rx_hs && (rx_data_q != byte_q) && (mis_q != 8'hFF)) begin
      mis_d = mis_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 8'h0;
    else        mis_q <= mis_d;
  end

  assign mismatch_cnt = mis_q;
`else
  assign mismatch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_xfer_ctrl.sv
// Randomized bench for uart_xfer_ctrl: ICB slave with a scripted CSR flag, byte source/sink,
// and a transaction-level reference of the expected bus traffic per byte.
`timescale 1ns/1ps
module tb_uart_xfer_ctrl;

  localparam logic [31:0] CSR_A  = 32'h1000_0000;
  localparam logic [31:0] CTRL_A = 32'h1000_0004;
  localparam logic [31:0] DATA_A = 32'h1000_0008;
  localparam int          PM     = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, busy, err_timeout;
  logic [31:0] cfg_csr, cfg_ctrl;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0]  tx_data, rx_data, mismatch_cnt;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic        icb_rsp_valid, icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;

  uart_xfer_ctrl #(.CSR_ADDR(CSR_A), .CTRL_ADDR(CTRL_A), .DATA_ADDR(DATA_A), .POLL_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_csr(cfg_csr), .cfg_ctrl(cfg_ctrl), .busy(busy), .err_timeout(err_timeout),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] wdata;
  } txn_t;

  txn_t       log_q[$], exp_q[$];
  logic [7:0] rx_got[$], exp_rx[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // slave script and observation state
  int          set_n, clr_n, csr_cnt, dly, wr_stall, wr_stall_seen, proto_viol;
  logic [7:0]  xmask, last_wb;
  bit          zero_wait, aft_rd, pend, prev_stalled, rx_stall, rx_prev_hold;
  logic [31:0] pend_rd, sl_r;
  txn_t        prev_c;
  logic [7:0]  rx_prev_data;
  int          rx_first_cyc, tx_acc_cyc;

  // reference state
  bit          err_exp;
  int          mis_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
  end

  initial begin : icb_slave
    icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_rdata = 32'h0;
    pend = 1'b0; dly = 0; prev_stalled = 1'b0; aft_rd = 1'b0; csr_cnt = 0; last_wb = 8'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; prev_stalled = 1'b0;
        icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0;
      end else begin
        if (icb_cmd_valid && !icb_cmd_read && icb_cmd_addr == DATA_A && wr_stall > 0) begin
          icb_cmd_ready = 1'b0;
          wr_stall--;
          wr_stall_seen++;
        end else begin
          icb_cmd_ready = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        icb_rsp_valid = pend && (dly == 0);
        icb_rsp_rdata = icb_rsp_valid ? pend_rd : $urandom;
        #1;
        if (prev_stalled && !(icb_cmd_valid && icb_cmd_addr == prev_c.addr &&
            icb_cmd_read == prev_c.rd && icb_cmd_wdata == prev_c.wdata)) proto_viol++;
        if (icb_cmd_valid && pend) proto_viol++;
        prev_stalled = icb_cmd_valid && !icb_cmd_ready;
        prev_c.addr  = icb_cmd_addr;
        prev_c.rd    = icb_cmd_read;
        prev_c.wdata = icb_cmd_wdata;
        if (icb_rsp_valid && icb_rsp_ready) pend = 1'b0;
        else if (pend && dly > 0) dly--;
        if (icb_cmd_valid && icb_cmd_ready) begin
          log_q.push_back(prev_c);
          sl_r = $urandom;
          if (prev_c.rd) begin
            if (prev_c.addr == CSR_A) begin
              csr_cnt++;
              sl_r[4] = aft_rd ? !(clr_n != 0 && csr_cnt >= clr_n) : (set_n != 0 && csr_cnt >= set_n);
            end else if (prev_c.addr == DATA_A) begin
              sl_r[7:0] = last_wb ^ xmask;
              aft_rd = 1'b1; csr_cnt = 0;
            end
          end else if (prev_c.addr == DATA_A) begin
            last_wb = prev_c.wdata[7:0];
            aft_rd = 1'b0; csr_cnt = 0;
          end
          pend_rd = sl_r;
          pend    = 1'b1;
          dly     = zero_wait ? 0 : $urandom_range(0, 2);
        end
      end
    end
  end

  initial begin : rx_sink
    rx_ready = 1'b0; rx_prev_hold = 1'b0; rx_prev_data = 8'h0;
    forever begin
      @(negedge clk);
      rx_ready = rx_stall ? 1'b0 : ($urandom_range(0, 2) != 0);
      #1;
      if (rx_valid && !rx_prev_hold) rx_first_cyc = cyc;
      if (rx_prev_hold && !(rx_valid && rx_data == rx_prev_data)) proto_viol++;
      if (rx_valid && icb_cmd_valid) proto_viol++;
      rx_prev_hold = rx_valid && !rx_ready;
      rx_prev_data = rx_data;
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_queues();
    log_q.delete(); exp_q.delete(); rx_got.delete(); exp_rx.delete();
  endtask

  task automatic wait_ready_or_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (tx_ready || !busy) begin ok = 1'b1; break; end
    end
    if (!ok) check_val("wait_bound", 32'd0, 32'd1);
  endtask

  task automatic compare_all();
    int n;
    check_val("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val("txn_addr", log_q[i].addr, exp_q[i].addr);
      check_val("txn_read", 32'(log_q[i].rd), 32'(exp_q[i].rd));
      if (!exp_q[i].rd) check_val("txn_wdata", log_q[i].wdata, exp_q[i].wdata);
    end
    check_val("rx_count", 32'(rx_got.size()), 32'(exp_rx.size()));
    n = (rx_got.size() < exp_rx.size()) ? rx_got.size() : exp_rx.size();
    for (int i = 0; i < n; i++) check_val("rx_byte", 32'(rx_got[i]), 32'(exp_rx[i]));
    check_val("err_timeout", 32'(err_timeout), 32'(err_exp));
`ifdef UART_XFER_LOOPCHK_EN
    check_val("mismatch_cnt", 32'(mismatch_cnt), 32'(mis_exp));
`else
    check_val("mismatch_cnt", 32'(mismatch_cnt), 32'd0);
`endif
    clear_queues();
  endtask

  task automatic do_start(input logic [31:0] c_csr, input logic [31:0] c_ctrl);
    @(negedge clk);
    cfg_csr = c_csr; cfg_ctrl = c_ctrl; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_csr = $urandom; cfg_ctrl = $urandom;
    #1;
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("err_cleared", 32'(err_timeout), 32'd0);
    err_exp = 1'b0; mis_exp = 0;
    exp_q.push_back('{CSR_A, 1'b0, c_csr});
    exp_q.push_back('{CTRL_A, 1'b0, c_ctrl});
    wait_ready_or_idle();
    check_val("tx_ready_after_cfg", 32'(tx_ready), 32'd1);
    compare_all();
  endtask

  // Expected bus traffic and returned data for one byte, from the flag script alone
  task automatic model_byte(input logic [7:0] b, input int sn, input int cn, input logic [7:0] xm);
    bit set_ok = (sn >= 1 && sn <= PM);
    bit clr_ok = (cn >= 1 && cn <= PM);
    exp_q.push_back('{DATA_A, 1'b0, {24'h0, b}});
    repeat (set_ok ? sn : PM) exp_q.push_back('{CSR_A, 1'b1, 32'h0});
    if (!set_ok) begin
      err_exp = 1'b1;
    end else begin
      exp_q.push_back('{DATA_A, 1'b1, 32'h0});
      exp_rx.push_back(b ^ xm);
      if (xm != 8'h0 && mis_exp < 255) mis_exp++;
      repeat (clr_ok ? cn : PM) exp_q.push_back('{CSR_A, 1'b1, 32'h0});
      if (!clr_ok) err_exp = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int sn, input int cn,
                           input logic [7:0] xm, input bit pulse_start);
    bit ok = 1'b0;
    set_n = sn; clr_n = cn; xmask = xm;
    @(negedge clk);
    tx_data = b; tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (tx_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check_val("tx_accept_bound", 32'd0, 32'd1);
    tx_acc_cyc = cyc;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = $urandom;
    if (pulse_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    model_byte(b, sn, cn, xm);
  endtask

  initial begin : main
    bit ok;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_csr = 32'h0; cfg_ctrl = 32'h0;
    tx_valid = 1'b0; tx_data = 8'h0;
    set_n = 1; clr_n = 1; xmask = 8'h0; zero_wait = 1'b0; wr_stall = 0; wr_stall_seen = 0;
    proto_viol = 0; rx_stall = 1'b0; err_exp = 1'b0; mis_exp = 0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_tx_ready", 32'(tx_ready), 32'd0);
    check_val("rst_cmd_valid", 32'(icb_cmd_valid), 32'd0);
    check_val("rst_rsp_ready", 32'(icb_rsp_ready), 32'd0);
    check_val("rst_err", 32'(err_timeout), 32'd0);
    check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("rst_rx_data", 32'(rx_data), 32'd0);
    check_val("rst_mismatch", 32'(mismatch_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // configuration writes
    do_start(32'h004D_0001, 32'h0001_0111);

    // byte with flag set on 3rd poll, cleared on 2nd clear-poll
    zero_wait = 1'b1;
    send_byte(8'hA5, 3, 2, 8'h00, 1'b0);
    wait_ready_or_idle();
    compare_all();

    // minimum accept-to-rx_valid latency
    send_byte(8'h3C, 1, 1, 8'h00, 1'b0);
    wait_ready_or_idle();
    check_val("latency", 32'(rx_first_cyc - tx_acc_cyc), 32'd7);
    compare_all();
    zero_wait = 1'b0;

    // command stall on the DATA write
    wr_stall = 5; wr_stall_seen = 0;
    send_byte(8'h5A, 2, 1, 8'h00, 1'b0);
    wait_ready_or_idle();
    check_val("wr_stall_cycles", 32'(wr_stall_seen), 32'd5);
    compare_all();

    // poll timeout, then stop and restart clears the flag
    send_byte(8'hC3, 0, 1, 8'h00, 1'b0);
    wait_ready_or_idle();
    check_val("timeout_flag", 32'(err_timeout), 32'd1);
    check_val("timeout_tx_ready", 32'(tx_ready), 32'd1);
    compare_all();
    @(negedge clk); stop = 1'b1;
    wait_ready_or_idle();
    @(negedge clk); #1;
    check_val("idle_after_stop", 32'(busy), 32'd0);
    stop = 1'b0;
    do_start(32'h0012_3403, 32'h0000_0007);

    // consumer stall in OUT_BYTE with stop raised mid-byte
    rx_stall = 1'b1;
    send_byte(8'h96, 2, 3, 8'h00, 1'b0);
    stop = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (rx_valid) begin ok = 1'b1; break; end
    end
    check_val("rx_valid_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check_val("stall_rx_valid", 32'(rx_valid), 32'd1);
      check_val("stall_rx_data", 32'(rx_data), 32'h96);
      check_val("stall_cmd_valid", 32'(icb_cmd_valid), 32'd0);
      check_val("stall_busy", 32'(busy), 32'd1);
      @(negedge clk); #1;
    end
    rx_stall = 1'b0;
    wait_ready_or_idle();
    check_val("stop_idle", 32'(busy), 32'd0);
    compare_all();
    stop = 1'b0;

    // randomized bytes, with occasional start pulses while busy and corrupted loopback
    do_start($urandom, $urandom);
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b, xm;
      b  = 8'($urandom);
      xm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_byte(b, $urandom_range(0, 10), $urandom_range(0, 10), xm, $urandom_range(0, 3) == 0);
      wait_ready_or_idle();
      compare_all();
    end

    // asynchronous reset in the middle of POLL_SET
    send_byte(8'h11, 0, 0, 8'h00, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (log_q.size() >= 3) begin ok = 1'b1; break; end
    end
    check_val("poll_reached", 32'(ok), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_cmd_valid", 32'(icb_cmd_valid), 32'd0);
    check_val("arst_tx_ready", 32'(tx_ready), 32'd0);
    check_val("arst_rsp_ready", 32'(icb_rsp_ready), 32'd0);
    check_val("arst_rx_data", 32'(rx_data), 32'd0);
    check_val("arst_err", 32'(err_timeout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
    err_exp = 1'b0; mis_exp = 0;
    do_start(32'h00AB_0001, 32'h0000_0102);
    send_byte(8'h7E, 1, 1, 8'h00, 1'b0);
    wait_ready_or_idle();
    compare_all();

    check_val("protocol_violations", 32'(proto_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
